pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 121 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Purpose : front-end PC redirect controller; merges branch and trap redirects,
//           defers the redirect behind an outstanding ibus fetch and squashes its response.
// Latency : 0 cycles when the ibus is idle (or its response lands the same cycle);
//           otherwise the redirect issues in the cycle the outstanding response returns.
// Backpressure: none upstream; a losing or ignored request is dropped, never queued.
// Ports:
//   clk, reset (sync, active-low)
//   br_redirect/br_target/stall_d   decode-stage redirect request, gated by stall_d
//   exc_redirect/exc_target         trap/xRET redirect request (highest priority)
//   fetch_busy/fetch_data_ok        ibus outstanding / response-returned status
//   redirect_valid/redirect_pc      load PC this cycle with the (halfword-aligned) target
//   flush_fd/flush_de/drop_resp     pipeline squash and fetch-response discard
//   redirect_cnt                    saturating count of issued redirects
module pc_redirect_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_redirect,
  input  logic [63:0]      br_target,
  input  logic             stall_d,
  input  logic             exc_redirect,
  input  logic [63:0]      exc_target,
  input  logic             fetch_busy,
  input  logic             fetch_data_ok,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             drop_resp,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_n;
  logic [63:0]        pend_pc, pend_pc_n;
  logic               pend_exc, pend_exc_n;
  logic [CNT_W-1:0]   cnt;

  logic               br_q, ex_q, req;
  logic [63:0]        req_tgt, exc_tgt;

  assign br_q    = br_redirect & ~stall_d;
  assign ex_q    = exc_redirect;
  assign req     = br_q | ex_q;
  // Exception wins a same-cycle collision; the branch is simply lost.
  assign req_tgt = (ex_q ? exc_target : br_target) & ~64'h1;
  assign exc_tgt = exc_target & ~64'h1;

  always_comb begin
    state_n        = state;
    pend_pc_n      = pend_pc;
    pend_exc_n     = pend_exc;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    flush_fd       = 1'b0;
    flush_de       = 1'b0;
    drop_resp      = 1'b0;
    // Everything stays quiet while reset is held, whatever the inputs do.
    if (reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            flush_fd = 1'b1;
            flush_de = ex_q;
            if (!fetch_busy) begin
              redirect_valid = 1'b1;
              redirect_pc    = req_tgt;
            end else if (fetch_data_ok) begin
              // Stale response lands right now: kill it and redirect at once.
              redirect_valid = 1'b1;
              redirect_pc    = req_tgt;
              drop_resp      = 1'b1;
            end else begin
              pend_pc_n  = req_tgt;
              pend_exc_n = ex_q;
              state_n    = WAIT;
            end
          end
        end
        WAIT: begin
          // Fetch keeps running on the old path until its response is
          // discarded, so the F/D register is squashed every cycle here.
          // Branches are ignored: their instruction is already squashed.
          flush_fd = 1'b1;
          if (ex_q) begin
            flush_de   = 1'b1;
            pend_pc_n  = exc_tgt;
            pend_exc_n = 1'b1;
          end
          if (fetch_data_ok) begin
            drop_resp      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = ex_q ? exc_tgt : pend_pc;
            state_n        = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pend_pc  <= 64'h0;
      pend_exc <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      pend_pc  <= pend_pc_n;
      pend_exc <= pend_exc_n;
      if (redirect_valid && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign redirect_cnt = reset ? cnt : '0;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose : self-checking bench for pc_redirect_ctrl (directed scenarios + random traffic).
// Latency : outputs are compared combinationally mid-cycle against a behavioural model.
// Backpressure: n/a.
module tb_pc_redirect_ctrl;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, br_redirect, stall_d, exc_redirect, fetch_busy, fetch_data_ok;
  logic [63:0]   br_target, exc_target;
  logic          redirect_valid, flush_fd, flush_de, drop_resp;
  logic [63:0]   redirect_pc;
  logic [CW-1:0] redirect_cnt;

  pc_redirect_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .br_redirect(br_redirect), .br_target(br_target), .stall_d(stall_d),
    .exc_redirect(exc_redirect), .exc_target(exc_target),
    .fetch_busy(fetch_busy), .fetch_data_ok(fetch_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_fd(flush_fd), .flush_de(flush_de), .drop_resp(drop_resp),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "is a redirect owed once the in-flight fetch returns",
  // the PC it is owed to, and how many redirects have been issued.
  bit          m_owed;
  logic [63:0] m_owed_pc;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle against the model,
  // then advance the model to what it should hold after the next edge.
  task automatic apply(input logic rst, input logic br, input logic [63:0] bt,
                       input logic st, input logic ex, input logic [63:0] et,
                       input logic busy, input logic dok);
    logic        ev, ef, ed, edr;
    logic [63:0] epc;
    int          ecnt;
    bit          n_owed;
    logic [63:0] n_pc;
    int          n_cnt;
    logic [63:0] want;
    bit          has_req;
    reset = rst; br_redirect = br; br_target = bt; stall_d = st;
    exc_redirect = ex; exc_target = et; fetch_busy = busy; fetch_data_ok = dok;
    @(negedge clk);
    ev = 0; ef = 0; ed = 0; edr = 0; epc = 64'h0;
    ecnt = rst ? m_cnt : 0;
    n_owed = m_owed; n_pc = m_owed_pc; n_cnt = m_cnt;
    has_req = ex || (br && !st);
    want = ex ? {et[63:1], 1'b0} : {bt[63:1], 1'b0};
    if (!rst) begin
      n_owed = 0; n_pc = 64'h0; n_cnt = 0;
    end else if (!m_owed) begin
      if (has_req) begin
        ef = 1; ed = ex;
        if (!busy || dok) begin
          ev = 1; epc = want; edr = busy && dok;
        end else begin
          n_owed = 1; n_pc = want;
        end
      end
    end else begin
      ef = 1;
      if (ex) begin
        ed = 1; n_pc = {et[63:1], 1'b0};
      end
      if (dok) begin
        ev = 1; edr = 1; epc = n_pc; n_owed = 0;
      end
    end
    if (rst && ev && n_cnt < CNT_MAX) n_cnt = n_cnt + 1;
    chk("redirect_valid", {63'h0, redirect_valid}, {63'h0, ev});
    chk("redirect_pc",    redirect_pc,             epc);
    chk("flush_fd",       {63'h0, flush_fd},       {63'h0, ef});
    chk("flush_de",       {63'h0, flush_de},       {63'h0, ed});
    chk("drop_resp",      {63'h0, drop_resp},      {63'h0, edr});
    chk("redirect_cnt",   {60'h0, redirect_cnt},   64'(ecnt));
    m_owed = n_owed; m_owed_pc = n_pc; m_cnt = n_cnt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic busy, input logic dok);
    apply(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, busy, dok);
  endtask

  initial begin
    m_owed = 0; m_owed_pc = 64'h0; m_cnt = 0;
    reset = 1'b0; br_redirect = 1'b0; br_target = 64'h0; stall_d = 1'b0;
    exc_redirect = 1'b0; exc_target = 64'h0; fetch_busy = 1'b0; fetch_data_ok = 1'b0;

    // Reset with noisy inputs: everything must read zero.
    apply(1'b0, 1'b1, 64'h55, 1'b0, 1'b1, 64'h77, 1'b0, 1'b1); tick;
    apply(1'b0, 1'b1, 64'h55, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("rst_valid", {63'h0, redirect_valid}, 64'h0);
    chk("rst_drop",  {63'h0, drop_resp},      64'h0);
    tick;

    // Zero-latency branch redirect with odd target.
    apply(1'b1, 1'b1, 64'h8000_1003, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("br0_valid", {63'h0, redirect_valid}, 64'h1);
    chk("br0_pc",    redirect_pc,             64'h8000_1002);
    chk("br0_fde",   {63'h0, flush_de},       64'h0);
    tick;
    idle(1'b0, 1'b0);
    chk("br0_cnt", {60'h0, redirect_cnt}, 64'h1);
    tick;

    // Deferred branch behind busy fetch, released three cycles later.
    apply(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("defer_valid", {63'h0, redirect_valid}, 64'h0);
    chk("defer_ffd",   {63'h0, flush_fd},       64'h1);
    tick;
    for (int i = 0; i < 2; i++) begin
      idle(1'b1, 1'b0);
      chk("wait_ffd", {63'h0, flush_fd}, 64'h1);
      tick;
    end
    idle(1'b1, 1'b1);
    chk("rel_valid", {63'h0, redirect_valid}, 64'h1);
    chk("rel_pc",    redirect_pc,             64'h100);
    chk("rel_drop",  {63'h0, drop_resp},      64'h1);
    tick;
    idle(1'b0, 1'b0);
    chk("rel_idle", {63'h0, flush_fd}, 64'h0);
    tick;

    // Exception during WAIT replaces the pending branch target.
    apply(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0); tick;
    apply(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 1'b1, 1'b0);
    chk("wexc_fde", {63'h0, flush_de}, 64'h1);
    tick;
    idle(1'b1, 1'b1);
    chk("wexc_pc", redirect_pc, 64'h8000_0000);
    tick;

    // Same-cycle branch and exception: exception wins, branch is lost.
    apply(1'b1, 1'b1, 64'h200, 1'b0, 1'b1, 64'h300, 1'b0, 1'b0);
    chk("prio_pc",  redirect_pc,        64'h300);
    chk("prio_fde", {63'h0, flush_de},  64'h1);
    tick;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0);
      chk("prio_none", {63'h0, redirect_valid}, 64'h0);
      tick;
    end

    // Stalled branch is invisible until decode unstalls.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 64'h440, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      chk("stall_ffd", {63'h0, flush_fd}, 64'h0);
      tick;
    end
    apply(1'b1, 1'b1, 64'h440, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("unstall_valid", {63'h0, redirect_valid}, 64'h1);
    tick;

    // Reset pulse while waiting abandons the pending redirect.
    apply(1'b1, 1'b1, 64'h900, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0); tick;
    apply(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0); tick;
    idle(1'b1, 1'b1);
    chk("rstw_drop",  {63'h0, drop_resp},      64'h0);
    chk("rstw_valid", {63'h0, redirect_valid}, 64'h0);
    chk("rstw_cnt",   {60'h0, redirect_cnt},   64'h0);
    tick;

    // Counter saturation.
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      apply(1'b1, 1'b1, 64'(i * 8), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick;
    end
    idle(1'b0, 1'b0);
    chk("cnt_sat", {60'h0, redirect_cnt}, 64'(CNT_MAX));
    tick;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic rr, rb, rs, re, rbusy, rdok;
      rr    = ($urandom_range(0, 63) != 0);
      rb    = ($urandom_range(0, 3) == 0);
      rs    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 7) == 0);
      rbusy = ($urandom_range(0, 2) != 0);
      rdok  = ($urandom_range(0, 3) == 0);
      apply(rr, rb, {$urandom, $urandom}, rs, re, {$urandom, $urandom}, rbusy, rdok);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
